// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream leaving the bram read sequencer.
// master drives data/valid/last, slave drives ready.
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Walks N words of a 1-cycle-latency bram and streams them out
// through a 2-entry skid buffer at one word per cycle.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rden,
  output logic [ADDR_WIDTH-1:0] rdaddr,
  input  logic [DATA_WIDTH-1:0] q,
  bram_stream_reader_if.master  s
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_rem;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_infl;
  logic                  r_infl_last;
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_d0;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  r_l0;
  logic                  r_l1;

  logic       w_start;
  logic       w_pop;
  logic       w_push;
  logic       w_rden;
  logic       w_rem_one;
  logic [2:0] w_occ;

  assign w_start   = start && (r_state == S_IDLE);
  assign w_pop     = s.out_valid && s.out_ready;
  assign w_push    = r_infl;
  assign w_rem_one = (r_rem == (ADDR_WIDTH+1)'(1));

  // Occupancy the next push would see: buffered + in flight - leaving now
  assign w_occ = {1'b0, r_cnt} + {2'b0, r_infl} - {2'b0, w_pop};

  assign w_rden = (r_state == S_STREAM) && (r_rem != '0)
               && (w_occ < 3'd2);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (length == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (w_rden && w_rem_one)
          w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_pop && s.out_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_addr      <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_infl      <= w_rden;
      r_infl_last <= w_rden && w_rem_one;
      if (w_start) begin
        r_rem  <= length;
        r_addr <= base_addr;
      end else if (w_rden) begin
        r_rem  <= r_rem - 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Head is always entry 0; entry 1 only fills while the head is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_l0  <= 1'b0;
      r_l1  <= 1'b0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_d0 <= q;
            r_l0 <= r_infl_last;
          end else begin
            r_d1 <= q;
            r_l1 <= r_infl_last;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_l0  <= r_l1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0 <= q;
            r_l0 <= r_infl_last;
          end else begin
            r_d0 <= r_d1;
            r_l0 <= r_l1;
            r_d1 <= q;
            r_l1 <= r_infl_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(r_infl && (r_cnt == 2'd2)) && (r_cnt != 2'd3)
  );

  assign busy        = (r_state != S_IDLE) || w_start;
  assign done        = (r_state == S_DONE);
  assign rden        = w_rden;
  assign rdaddr      = r_addr;
  assign s.out_valid = (r_cnt != 2'd0);
  assign s.out_data  = r_d0;
  assign s.out_last  = r_l0;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: table of commands, random commands,
// and directed reset/second-start sequences against a queue model.
module tb_bram_stream_reader;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
  logic          rden;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] q = '0;

  bram_stream_reader_if #(.DATA_WIDTH(DW)) intf ();

  bram_stream_reader #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .rden     (rden),
    .rdaddr   (rdaddr),
    .q        (q),
    .s        (intf)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (rden) q <= mem[rdaddr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: expected words and read addresses in order
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  bit            mon_en = 1'b0;
  int            cyc_no = 0;
  int            t0 = 0;
  int            outst, n_done, n_hs, first_valid, done_cyc, busy_cnt;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic          m_pop;
  logic [DW:0]   m_e;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) if (mon_en) begin
    m_pop = intf.out_valid && intf.out_ready;
    if (busy) busy_cnt++;
    if (rden) begin
      if (addr_q.size() == 0) chk("extra_rden", 1, 0);
      else chk("rdaddr", 32'(rdaddr), 32'(addr_q.pop_front()));
      chk("rden_room", 32'((outst - int'(m_pop)) < 2), 1);
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(intf.out_valid), 1);
      chk("stall_data", 32'(intf.out_data), 32'(prev_data));
      chk("stall_last", 32'(intf.out_last), 32'(prev_last));
    end
    if (intf.out_valid && first_valid < 0) first_valid = cyc_no - t0;
    if (m_pop) begin
      if (exp_q.size() == 0) chk("extra_word", 1, 0);
      else begin
        m_e = exp_q.pop_front();
        chk("out_data", 32'(intf.out_data), 32'(m_e[DW-1:0]));
        chk("out_last", 32'(intf.out_last), 32'(m_e[DW]));
      end
      n_hs++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc_no - t0;
    end
    outst      = outst + int'(rden) - int'(m_pop);
    prev_stall = intf.out_valid && !intf.out_ready;
    prev_data  = intf.out_data;
    prev_last  = intf.out_last;
  end

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic arm(input logic [AW-1:0] b, input logic [AW:0] n);
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back({1'(i == int'(n) - 1), mem[(int'(b) + i) % DEPTH]});
      addr_q.push_back(AW'((int'(b) + i) % DEPTH));
    end
    outst = 0; n_done = 0; n_hs = 0; busy_cnt = 0;
    first_valid = -1; done_cyc = -1; prev_stall = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW:0] n,
                         input int mode, input int e_first,
                         input int e_done, input int e_busy,
                         input int extra_at);
    int k;
    arm(b, n);
    intf.out_ready = rdy(mode, 0);
    base_addr = b;
    length    = n;
    start     = 1'b1;
    cyc();
    t0 = cyc_no;
    k  = 0;
    while (n_done == 0 && k < 300) begin
      start = (k == extra_at);
      if (start) begin
        base_addr = b + 4'd5;
        length    = 5'd2;
      end
      intf.out_ready = rdy(mode, k);
      cyc();
      k++;
    end
    start = 1'b0;
    chk("done_seen", 32'(n_done), 1);
    intf.out_ready = 1'b1;
    cyc();
    cyc();
    chk("done_once", 32'(n_done), 1);
    chk("words_left", 32'(exp_q.size()), 0);
    chk("reads_left", 32'(addr_q.size()), 0);
    chk("busy_after", 32'(busy), 0);
    chk("first_valid", 32'(first_valid), 32'(e_first));
    if (e_done >= 0) chk("done_cycle", 32'(done_cyc), 32'(e_done));
    if (e_busy >= 0) chk("busy_cycles", 32'(busy_cnt), 32'(e_busy));
    mon_en = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rden"}, 32'(rden), 0);
    chk({tag, "_rdaddr"}, 32'(rdaddr), 0);
    chk({tag, "_valid"}, 32'(intf.out_valid), 0);
    chk({tag, "_data"}, 32'(intf.out_data), 0);
    chk({tag, "_last"}, 32'(intf.out_last), 0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    int            e_first;
    int            e_done;
    int            e_busy;
    int            extra_at;
  } vec_t;

  vec_t vt [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'd0,  5'd4,  0, 2,  6,  8, -1};
    vt[1] = '{4'd10, 5'd6,  1, 2, -1, -1, -1};
    vt[2] = '{4'd14, 5'd4,  0, 2,  6,  8, -1};
    vt[3] = '{4'd3,  5'd0,  0, -1, 0,  2, -1};
    vt[4] = '{4'd3,  5'd5,  0, 2,  7,  9,  2};
    vt[5] = '{4'd0,  5'd16, 0, 2, 18, 20, -1};
    vt[6] = '{4'd5,  5'd1,  0, 2,  3,  5, -1};
    vt[7] = '{4'd7,  5'd3,  2, 2, -1, -1, -1};

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    intf.out_ready = 1'b1;

    repeat (3) cyc();
    chk_zero("reset");
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++)
      run_cmd(vt[i].base, vt[i].len, vt[i].mode, vt[i].e_first,
              vt[i].e_done, vt[i].e_busy, vt[i].extra_at);

    // Reset lands mid-command after three words have gone out
    begin
      int k;
      arm(4'd0, 5'd8);
      base_addr = '0;
      length    = 5'd8;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      t0 = cyc_no;
      k  = 0;
      while (n_hs < 3 && k < 50) begin
        cyc();
        k++;
      end
      chk("pre_reset_hs", 32'(n_hs), 3);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      for (int i = 0; i < 4; i++) begin
        cyc();
        chk("rst_no_done", 32'(done), 0);
      end
      rst_n = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
        cyc();
        chk("post_rst_no_done", 32'(done), 0);
      end
      run_cmd(4'd0, 5'd2, 0, 2, 4, 6, -1);
    end

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 25; i++) begin
      logic [AW-1:0] b;
      logic [AW:0]   n;
      int            m;
      b = AW'($urandom_range(0, DEPTH - 1));
      n = (AW+1)'($urandom_range(0, DEPTH));
      m = $urandom_range(0, 2);
      run_cmd(b, n, m, (n == 0) ? -1 : 2,
              (m != 0) ? -1 : ((n == 0) ? 0 : int'(n) + 2),
              (m != 0) ? -1 : ((n == 0) ? 2 : int'(n) + 4),
              (i % 4 == 0) ? 1 : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
